// File: rtl/alu_requester.sv
// alu_requester: initiator side of the ALU request/valid interface.
// Accepts one tagged command at a time on a ready/valid port, issues it to the
// ALU as a single-cycle request, waits for the ALU valid pulse (with a timeout
// guard) and returns the result plus tag on a ready/valid response port.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   cmd_valid/cmd_ready           upstream command handshake
//   cmd_a, cmd_b, cmd_op, cmd_tag command payload (op: 0 add, 1 sub, 2 and, 3 or)
//   alu_request                   one-cycle request pulse to the ALU
//   alu_operandA/B, alu_opcode    operands/opcode held stable through WAIT
//   alu_result, alu_valid         ALU return path (valid honoured only in WAIT)
//   rsp_valid/rsp_ready           downstream response handshake
//   rsp_result, rsp_tag, rsp_error response payload (error = ALU timeout)
//   done_count                    responses handed off since reset, wraps
module alu_requester #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned TIMEOUT = 8,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [1:0]       cmd_op,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic             alu_request,
    output logic [WIDTH-1:0] alu_operandA,
    output logic [WIDTH-1:0] alu_operandB,
    output logic [1:0]       alu_opcode,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_valid,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_error,
    output logic [CNT_W-1:0] done_count
);

    // Wait counter is wide enough for the largest legal TIMEOUT (255)
    localparam int unsigned WCNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                alu_request_q, alu_request_d;
    logic [WIDTH-1:0]    opa_q, opa_d;
    logic [WIDTH-1:0]    opb_q, opb_d;
    logic [1:0]          op_q, op_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [WCNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [WCNT_W-1:0]   wait_cnt_inc;
    logic                rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]    rsp_result_q, rsp_result_d;
    logic                rsp_error_q, rsp_error_d;
    logic [CNT_W-1:0]    done_cnt_q, done_cnt_d;

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cmd_ready_q   <= 1'b1;
            alu_request_q <= 1'b0;
            opa_q         <= '0;
            opb_q         <= '0;
            op_q          <= '0;
            tag_q         <= '0;
            wait_cnt_q    <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_result_q  <= '0;
            rsp_error_q   <= 1'b0;
            done_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            alu_request_q <= alu_request_d;
            opa_q         <= opa_d;
            opb_q         <= opb_d;
            op_q          <= op_d;
            tag_q         <= tag_d;
            wait_cnt_q    <= wait_cnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_result_q  <= rsp_result_d;
            rsp_error_q   <= rsp_error_d;
            done_cnt_q    <= done_cnt_d;
        end
    end

    assign wait_cnt_inc = wait_cnt_q + WCNT_W'(1);

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        opa_d        = opa_q;
        opb_d        = opb_q;
        op_d         = op_q;
        tag_d        = tag_q;
        wait_cnt_d   = wait_cnt_q;
        rsp_result_d = rsp_result_q;
        rsp_error_d  = rsp_error_q;
        done_cnt_d   = done_cnt_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    opa_d   = cmd_a;
                    opb_d   = cmd_b;
                    op_d    = cmd_op;
                    tag_d   = cmd_tag;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                wait_cnt_d = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                wait_cnt_d = wait_cnt_inc;
                // A valid arriving on the timeout cycle still counts as success
                if (alu_valid) begin
                    rsp_result_d = alu_result;
                    rsp_error_d  = 1'b0;
                    state_d      = RESP;
                end else if (wait_cnt_inc == WCNT_W'(TIMEOUT)) begin
                    rsp_result_d = '0;
                    rsp_error_d  = 1'b1;
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    done_cnt_d = done_cnt_q + CNT_W'(1);
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshake/request outputs are registered copies of the next state
        cmd_ready_d   = (state_d == IDLE);
        alu_request_d = (state_d == ISSUE);
        rsp_valid_d   = (state_d == RESP);
    end

    assign cmd_ready    = cmd_ready_q;
    assign alu_request  = alu_request_q;
    assign alu_operandA = opa_q;
    assign alu_operandB = opb_q;
    assign alu_opcode   = op_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_result   = rsp_result_q;
    assign rsp_tag      = tag_q;
    assign rsp_error    = rsp_error_q;
    assign done_count   = done_cnt_q;

endmodule

// File: tb/tb_alu_requester.sv
// Testbench for alu_requester: directed table of commands plus hand-written
// sequences for backpressure, timeout, late/stray valid, reset and wrap.
module tb_alu_requester;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned TAG_W   = 4;
    localparam int unsigned TIMEOUT = 8;
    localparam int unsigned CNT_W   = 4;

    logic             clk;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic [1:0]       cmd_op;
    logic [TAG_W-1:0] cmd_tag;
    logic             alu_request;
    logic [WIDTH-1:0] alu_operandA;
    logic [WIDTH-1:0] alu_operandB;
    logic [1:0]       alu_opcode;
    logic [WIDTH-1:0] alu_result;
    logic             alu_valid;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_error;
    logic [CNT_W-1:0] done_count;

    alu_requester #(
        .WIDTH(WIDTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
        .alu_request(alu_request), .alu_operandA(alu_operandA),
        .alu_operandB(alu_operandB), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_valid(alu_valid),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_tag(rsp_tag), .rsp_error(rsp_error),
        .done_count(done_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU model: answers alu_delay cycles after a request when enabled
    logic             alu_en;
    int               alu_delay;
    logic             m_valid;
    logic [WIDTH-1:0] m_res;
    logic             pend;
    int               left;
    logic             inj_valid;
    logic [WIDTH-1:0] inj_res;

    function automatic logic [WIDTH-1:0] alu_fn(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic [1:0] op);
        case (op)
            2'd0:    alu_fn = a + b;
            2'd1:    alu_fn = a - b;
            2'd2:    alu_fn = a & b;
            default: alu_fn = a | b;
        endcase
    endfunction

    initial begin
        m_valid = 1'b0;
        m_res   = '0;
        pend    = 1'b0;
        left    = 0;
    end

    always @(posedge clk) begin
        m_valid <= 1'b0;
        if (alu_request && alu_en) begin
            m_res <= alu_fn(alu_operandA, alu_operandB, alu_opcode);
            if (alu_delay <= 1) begin
                m_valid <= 1'b1;
                pend    <= 1'b0;
            end else begin
                pend <= 1'b1;
                left <= alu_delay - 1;
            end
        end else if (pend) begin
            if (left == 1) begin
                m_valid <= 1'b1;
                pend    <= 1'b0;
            end
            left <= left - 1;
        end
    end

    assign alu_valid  = m_valid | inj_valid;
    assign alu_result = inj_valid ? inj_res : m_res;

    // Scoreboard counters
    int n_pass;
    int n_total;
    int exp_done;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [1:0]       op;
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] exp_res;
    } vec_t;

    vec_t vecs[8];

    // Drive one command, follow it through to the handshake and check it all.
    // exp_cyc: negedges from the ISSUE cycle until rsp_valid is seen.
    task automatic do_cmd(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [1:0] op, input logic [TAG_W-1:0] tag,
                          input logic [WIDTH-1:0] exp_res, input logic exp_err,
                          input int exp_cyc, input int bp, input bit hold);
        int n;
        int cyc;
        int reqs;
        int nready;
        cmd_valid = 1'b1;
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        cmd_tag   = tag;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", 32'(cmd_ready), 32'd1);
        rsp_ready = (bp == 0);
        @(negedge clk);
        if (!hold) cmd_valid = 1'b0;
        check("issue_req", 32'(alu_request), 32'd1);
        check("issue_operands", 32'({alu_operandA, alu_operandB, alu_opcode}),
              32'({a, b, op}));
        cyc = 0;
        reqs = 0;
        nready = 0;
        while (!rsp_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
            reqs += int'(alu_request);
            nready += int'(cmd_ready);
        end
        check("rsp_latency", 32'(cyc), 32'(exp_cyc));
        check("single_req", 32'(reqs), 32'd0);
        check("cmd_ready_low", 32'(nready), 32'd0);
        check("rsp_payload", 32'({rsp_result, rsp_tag, rsp_error}),
              32'({exp_res, tag, exp_err}));
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            check("bp_hold",
                  32'({rsp_valid, rsp_result, rsp_tag, rsp_error, cmd_ready, done_count}),
                  32'({1'b1, exp_res, tag, exp_err, 1'b0, CNT_W'(exp_done)}));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        exp_done = (exp_done + 1) % (1 << CNT_W);
        check("post_hs", 32'({rsp_valid, cmd_ready, done_count}),
              32'({1'b0, 1'b1, CNT_W'(exp_done)}));
    endtask

    initial begin
        int seen;
        n_pass    = 0;
        n_total   = 0;
        exp_done  = 0;
        alu_en    = 1'b1;
        alu_delay = 1;
        inj_valid = 1'b0;
        inj_res   = '0;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_op    = '0;
        cmd_tag   = '0;
        rsp_ready = 1'b1;

        vecs[0] = '{8'h05, 8'h03, 2'd0, 4'h1, 8'h08};
        vecs[1] = '{8'h03, 8'h05, 2'd1, 4'h2, 8'hFE};
        vecs[2] = '{8'hF0, 8'h3C, 2'd2, 4'h3, 8'h30};
        vecs[3] = '{8'hF0, 8'h0F, 2'd3, 4'h4, 8'hFF};
        vecs[4] = '{8'hFF, 8'h01, 2'd0, 4'h5, 8'h00};
        vecs[5] = '{8'h00, 8'h01, 2'd1, 4'h6, 8'hFF};
        vecs[6] = '{8'hA5, 8'h5A, 2'd2, 4'h7, 8'h00};
        vecs[7] = '{8'h80, 8'h7F, 2'd3, 4'hF, 8'hFF};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_ctrl", 32'({cmd_ready, alu_request, rsp_valid, rsp_error}),
              32'(4'b1000));
        check("reset_data",
              32'({alu_operandA, alu_operandB, alu_opcode, rsp_result, rsp_tag, done_count}),
              32'd0);

        // Table: nominal 1-cycle ALU, cmd_valid held high between commands
        for (int i = 0; i < 8; i++) begin
            do_cmd(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].tag, vecs[i].exp_res,
                   1'b0, 2, 0, (i != 7));
        end

        // Downstream backpressure for 5 cycles
        do_cmd(8'h12, 8'h34, 2'd0, 4'h9, 8'h46, 1'b0, 2, 5, 1'b0);

        // Timeout: ALU never answers
        alu_en = 1'b0;
        do_cmd(8'h11, 8'h22, 2'd0, 4'hA, 8'h00, 1'b1, 9, 0, 1'b0);
        alu_en = 1'b1;

        // Stray valid pulses in IDLE are ignored
        inj_res   = 8'hAA;
        inj_valid = 1'b1;
        seen = 0;
        repeat (2) begin
            @(negedge clk);
            seen += int'(rsp_valid) + int'(!cmd_ready);
        end
        inj_valid = 1'b0;
        check("idle_valid_ignored", 32'(seen), 32'd0);
        do_cmd(8'h09, 8'h04, 2'd1, 4'hB, 8'h05, 1'b0, 2, 0, 1'b0);

        // Valid on the last WAIT cycle wins over the timeout
        alu_delay = 8;
        do_cmd(8'h0F, 8'hF0, 2'd3, 4'hC, 8'hFF, 1'b0, 9, 0, 1'b0);
        // One cycle too late: timeout, then the late valid lands in RESP
        alu_delay = 9;
        do_cmd(8'h0F, 8'hF0, 2'd3, 4'hD, 8'h00, 1'b1, 9, 0, 1'b0);
        alu_delay = 1;
        @(negedge clk);
        check("late_valid_no_rsp", 32'({rsp_valid, cmd_ready}), 32'(2'b01));

        // Reset during WAIT; the ALU answers afterwards
        alu_delay = 5;
        cmd_valid = 1'b1;
        cmd_a     = 8'h33;
        cmd_b     = 8'h44;
        cmd_op    = 2'd0;
        cmd_tag   = 4'hE;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("rst_issue_req", 32'(alu_request), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_done = 0;
        check("rst_mid_ctrl", 32'({cmd_ready, alu_request, rsp_valid, done_count}),
              32'({1'b1, 1'b0, 1'b0, CNT_W'(0)}));
        check("rst_mid_data", 32'({alu_operandA, rsp_tag}), 32'd0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            seen += int'(rsp_valid);
        end
        check("rst_late_no_rsp", 32'(seen), 32'd0);
        alu_delay = 1;

        // 17 completions wrap a 4-bit counter to 1
        for (int i = 0; i < 17; i++) begin
            do_cmd(vecs[i % 8].a, vecs[i % 8].b, vecs[i % 8].op, vecs[i % 8].tag,
                   vecs[i % 8].exp_res, 1'b0, 2, 0, 1'b0);
        end
        check("wrap_count", 32'(done_count), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_requester.md
Name: alu_requester

Overview:
- Initiator side of the ALU request/valid interface.
- Accepts tagged commands on a ready/valid upstream port and issues each one to the ALU as a single-cycle request.
- Waits for the ALU valid pulse, with a timeout guard, and returns the result with its tag on a ready/valid response port.
- Sits between the testbench/transactor command queue and the ALU instance.

Parameters:
- WIDTH, 8, operand/result width; matches the ALU width.
- TAG_W, 4, command tag width.
- TIMEOUT, 8, maximum WAIT cycles before an error response; legal range 1..255.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- cmd_valid  in  1  upstream command present
- cmd_ready  out  1  requester can accept a command
- cmd_a  in  WIDTH  operand A
- cmd_b  in  WIDTH  operand B
- cmd_op  in  2  opcode: 0 add, 1 sub, 2 and, 3 or
- cmd_tag  in  TAG_W  command tag
- alu_request  out  1  request to ALU
- alu_operandA  out  WIDTH  operand A to ALU
- alu_operandB  out  WIDTH  operand B to ALU
- alu_opcode  out  2  opcode to ALU
- alu_result  in  WIDTH  ALU result
- alu_valid  in  1  ALU result valid
- rsp_valid  out  1  response present
- rsp_ready  in  1  downstream accepts response
- rsp_result  out  WIDTH  captured result
- rsp_tag  out  TAG_W  tag of the completed command
- rsp_error  out  1  1 = timeout, no ALU valid seen
- done_count  out  CNT_W  responses handed off since reset; wraps

Behaviour:
- Reset: clk and reset are as declared (reset synchronous, active-high; clock clk). Reset forces the following:
  - state = IDLE, cmd_ready = 1, alu_request = 0.
  - alu_operandA/B = 0, alu_opcode = 0.
  - rsp_valid = 0, rsp_result = 0, rsp_tag = 0, rsp_error = 0, done_count = 0.
  - Wait counter = 0.
- Reset mid-operation discards the in-flight command. No response is produced for it. alu_request is low from the cycle after reset is sampled.
- State machine states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready: latch a/b/op/tag into alu_operandA/B, alu_opcode and the tag register; next state = ISSUE.
- ISSUE:
  - alu_request = 1 for exactly this one cycle.
  - Operands and opcode are stable from ISSUE through WAIT.
  - Wait counter cleared; next state = WAIT.
- WAIT:
  - alu_request = 0; wait counter increments each cycle.
  - If alu_valid = 1: capture alu_result into rsp_result, set rsp_error = 0, next state = RESP.
  - Else if counter reaches TIMEOUT: set rsp_result = 0, rsp_error = 1, next state = RESP.
  - If alu_valid and timeout occur in the same cycle, alu_valid wins (rsp_error = 0).
- RESP:
  - rsp_valid = 1; rsp_result, rsp_tag and rsp_error are held stable while rsp_ready = 0.
  - On rsp_ready: done_count increments, including error responses; next state = IDLE; rsp_valid falls the next cycle.
- cmd_ready = 0 in ISSUE, WAIT and RESP. There is no command overlap, so there is at most one outstanding ALU request.
- alu_valid is ignored in every state except WAIT. This covers a stale valid carried over from an earlier request.
- Latency with a nominal 1-cycle ALU and rsp_ready held high:
  - Command accepted at cycle N → alu_request at N+1 → alu_valid seen at N+2 → rsp_valid at N+3 → IDLE at N+4.
  - Peak throughput is one command per 4 cycles.
- Arithmetic is performed only by the ALU. The requester never modifies result bits.
- done_count wraps from 2^CNT_W−1 to 0.

Test Plan:
- Reset, then cmd a=8'h05, b=8'h03, op=0, tag=1 with rsp_ready=1 → single alu_request pulse at N+1; rsp_valid at N+3 with result 8'h08, tag 1, error 0; done_count=1.
- Back-to-back commands op=1 (8'h03−8'h05), op=2 (8'hF0&8'h3C), op=3 (8'hF0|8'h0F), cmd_valid held high:
  - cmd_ready low between accepts.
  - Results 8'hFE, 8'h30, 8'hFF with matching tags, in order.
- Downstream backpressure: rsp_ready=0 for 5 cycles during RESP → rsp_valid, result and tag stay stable; cmd_ready stays 0; done_count increments only on the cycle rsp_ready=1.
- Timeout: ALU model never asserts valid, TIMEOUT=8 → RESP entered after 8 WAIT cycles with error=1, result=0. Then alu_valid pulsing in IDLE is ignored, and the next command completes normally.
- Reset asserted during WAIT → next cycle: IDLE, alu_request=0, rsp_valid=0, done_count=0; a late alu_valid produces no response.
- Counter wrap with CNT_W=4: 17 completed commands → done_count reads 1.
